// File: rtl/cla_nibble_serial_adder.sv
// Nibble-serial WIDTH-bit adder that reuses one 4-bit carry-lookahead slice per clock.
// Defining CLA_SERIAL_SUB_EN adds the `sub` port, which selects A - B.

module carry_lookahead_adder_4bits (
   input  logic [3:0] in0,
   input  logic [3:0] in1,
   input  logic       carry_in,
   output logic [3:0] sum,
   output logic       carry_out,
   output logic       PG,
   output logic       GG
);
   logic [3:0] p;
   logic [3:0] g;
   logic [4:1] c;

   assign p = in0 ^ in1;
   assign g = in0 & in1;

   // Every carry is flattened against carry_in, so no carry waits on a lower one.
   assign c[1] = g[0] | (p[0] & carry_in);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry_in);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & carry_in);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & carry_in);

   assign sum       = p ^ {c[3:1], carry_in};
   assign carry_out = c[4];
   assign PG        = &p;
   assign GG        = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
endmodule

module cla_nibble_serial_adder #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             carry_in,
`ifdef CLA_SERIAL_SUB_EN
   input  logic             sub,
`endif
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             overflow,
   output logic             busy
);
   localparam int N  = WIDTH / 4;
   localparam int KW = (N > 1) ? $clog2(N) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(N - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [KW-1:0]    k_q, k_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic [3:0] nib_a;
   logic [3:0] nib_b;
   logic [3:0] nib_sum;
   logic       nib_cout;
   logic       unused_pg;
   logic       unused_gg;
   logic       b_flip;
   logic       c_load;

`ifdef CLA_SERIAL_SUB_EN
   assign b_flip = sub;
   assign c_load = sub | carry_in;
`else
   assign b_flip = 1'b0;
   assign c_load = carry_in;
`endif

   // b_q holds B' (already inverted for subtraction), so the overflow term sees the real slice operand.
   assign nib_a = a_q[4*k_q +: 4];
   assign nib_b = b_q[4*k_q +: 4];

   carry_lookahead_adder_4bits u_slice (
      .in0       (nib_a),
      .in1       (nib_b),
      .carry_in  (carry_q),
      .sum       (nib_sum),
      .carry_out (nib_cout),
      .PG        (unused_pg),
      .GG        (unused_gg)
   );

   always_comb begin
      // NOTE: every variable gets its hold value first, so no path through the case infers a latch.
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      k_d     = k_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;

      unique case (state_q)
         IDLE: begin
            if (start_valid) begin
               a_d     = op_a;
               b_d     = op_b ^ {WIDTH{b_flip}};
               sum_d   = '0;
               k_d     = '0;
               carry_d = c_load;
               state_d = RUN;
            end
         end
         RUN: begin
            sum_d[4*k_q +: 4] = nib_sum;
            carry_d           = nib_cout;
            k_d               = k_q + 1'b1;
            if (k_q == K_LAST) begin
               k_d     = '0;
               cout_d  = nib_cout;
               ovf_d   = (a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ nib_sum[3]) ^ nib_cout;
               state_d = DONE;
            end
         end
         DONE: begin
            if (res_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         k_q     <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         k_q     <= k_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign start_ready = (state_q == IDLE);
   assign res_valid   = (state_q == DONE);
   assign busy        = (state_q != IDLE);
   assign sum         = sum_q;
   assign carry_out   = cout_q;
   assign overflow    = ovf_q;
endmodule
